// File: rtl/mnemonic_decoder.sv
// Tokenises an ASCII stream into RV32 mnemonics and returns {opcode, funct7, funct3, fmt}
// or a classified error over valid/ready. Define RV32M_EN to add the M-extension mnemonics.
module mnemonic_decoder #(
    parameter int MAX_LEN = 6
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       char_valid_in,
    input  logic [7:0] char_in,
    output logic       char_ready_out,
    input  logic       abort_in,
    output logic       result_valid_out,
    input  logic       result_ready_in,
    output logic [6:0] opcode_out,
    output logic [6:0] funct7_out,
    output logic [2:0] funct3_out,
    output logic [2:0] fmt_out,
    output logic       error_out,
    output logic [1:0] err_code_out
);
    localparam int BW = MAX_LEN * 5;
    localparam logic [4:0] COMPRESSED__ = 5'd0;
    localparam logic [6:0] OP_REG = 7'b0110011, OP_IMM = 7'b0010011, OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
    localparam logic [6:0] F7_0 = 7'b0000000, F7_ALT = 7'b0100000, F7_MUL = 7'b0000001;
    localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5;
    localparam logic [1:0] E_NONE = 2'd0, E_CHAR = 2'd1, E_LONG = 2'd2, E_UNKNOWN = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_DISCARD, S_LOOKUP, S_RESULT} state_t;

    // Right-aligned compressed key of a lowercase name, padded with the filler code.
    function automatic logic [BW-1:0] key(input logic [63:0] s);
        logic [BW-1:0] k;
        k = {MAX_LEN{COMPRESSED__}};
        for (int i = 7; i >= 0; i--)
            if (s[i*8 +: 8] != 8'd0)
                k = {k[BW-6:0], 5'(s[i*8 +: 8] - 8'h60)};
        return k;
    endfunction

    function automatic logic [20:0] ent(input logic [6:0] op, input logic [6:0] f7,
                                        input logic [2:0] f3, input logic [2:0] fmt);
        return {1'b1, op, f7, f3, fmt};
    endfunction

    // Returns {hit, opcode, funct7, funct3, fmt}.
    function automatic logic [20:0] lookup(input logic [BW-1:0] b);
        logic [20:0] r;
        r = '0;
        case (b)
            key(64'("add")):   r = ent(OP_REG, F7_0, 3'd0, F_R);
            key(64'("sub")):   r = ent(OP_REG, F7_ALT, 3'd0, F_R);
            key(64'("sll")):   r = ent(OP_REG, F7_0, 3'd1, F_R);
            key(64'("slt")):   r = ent(OP_REG, F7_0, 3'd2, F_R);
            key(64'("sltu")):  r = ent(OP_REG, F7_0, 3'd3, F_R);
            key(64'("xor")):   r = ent(OP_REG, F7_0, 3'd4, F_R);
            key(64'("srl")):   r = ent(OP_REG, F7_0, 3'd5, F_R);
            key(64'("sra")):   r = ent(OP_REG, F7_ALT, 3'd5, F_R);
            key(64'("or")):    r = ent(OP_REG, F7_0, 3'd6, F_R);
            key(64'("and")):   r = ent(OP_REG, F7_0, 3'd7, F_R);
            key(64'("addi")):  r = ent(OP_IMM, F7_0, 3'd0, F_I);
            key(64'("slli")):  r = ent(OP_IMM, F7_0, 3'd1, F_I);
            key(64'("slti")):  r = ent(OP_IMM, F7_0, 3'd2, F_I);
            key(64'("sltiu")): r = ent(OP_IMM, F7_0, 3'd3, F_I);
            key(64'("xori")):  r = ent(OP_IMM, F7_0, 3'd4, F_I);
            key(64'("srli")):  r = ent(OP_IMM, F7_0, 3'd5, F_I);
            key(64'("srai")):  r = ent(OP_IMM, F7_ALT, 3'd5, F_I);
            key(64'("ori")):   r = ent(OP_IMM, F7_0, 3'd6, F_I);
            key(64'("andi")):  r = ent(OP_IMM, F7_0, 3'd7, F_I);
            key(64'("lb")):    r = ent(OP_LOAD, F7_0, 3'd0, F_I);
            key(64'("lh")):    r = ent(OP_LOAD, F7_0, 3'd1, F_I);
            key(64'("lw")):    r = ent(OP_LOAD, F7_0, 3'd2, F_I);
            key(64'("lbu")):   r = ent(OP_LOAD, F7_0, 3'd4, F_I);
            key(64'("lhu")):   r = ent(OP_LOAD, F7_0, 3'd5, F_I);
            key(64'("sb")):    r = ent(OP_STORE, F7_0, 3'd0, F_S);
            key(64'("sh")):    r = ent(OP_STORE, F7_0, 3'd1, F_S);
            key(64'("sw")):    r = ent(OP_STORE, F7_0, 3'd2, F_S);
            key(64'("beq")):   r = ent(OP_BRANCH, F7_0, 3'd0, F_B);
            key(64'("bne")):   r = ent(OP_BRANCH, F7_0, 3'd1, F_B);
            key(64'("blt")):   r = ent(OP_BRANCH, F7_0, 3'd4, F_B);
            key(64'("bge")):   r = ent(OP_BRANCH, F7_0, 3'd5, F_B);
            key(64'("bltu")):  r = ent(OP_BRANCH, F7_0, 3'd6, F_B);
            key(64'("bgeu")):  r = ent(OP_BRANCH, F7_0, 3'd7, F_B);
            key(64'("lui")):   r = ent(OP_LUI, F7_0, 3'd0, F_U);
            key(64'("auipc")): r = ent(OP_AUIPC, F7_0, 3'd0, F_U);
            key(64'("jal")):   r = ent(OP_JAL, F7_0, 3'd0, F_J);
            key(64'("jalr")):  r = ent(OP_JALR, F7_0, 3'd0, F_I);
`ifdef RV32M_EN
            key(64'("mul")):    r = ent(OP_REG, F7_MUL, 3'd0, F_R);
            key(64'("mulh")):   r = ent(OP_REG, F7_MUL, 3'd1, F_R);
            key(64'("mulhsu")): r = ent(OP_REG, F7_MUL, 3'd2, F_R);
            key(64'("mulhu")):  r = ent(OP_REG, F7_MUL, 3'd3, F_R);
            key(64'("div")):    r = ent(OP_REG, F7_MUL, 3'd4, F_R);
            key(64'("divu")):   r = ent(OP_REG, F7_MUL, 3'd5, F_R);
            key(64'("rem")):    r = ent(OP_REG, F7_MUL, 3'd6, F_R);
            key(64'("remu")):   r = ent(OP_REG, F7_MUL, 3'd7, F_R);
`else
            key(64'("mul")):    r = '0;
`endif
            default:            r = '0;
        endcase
        return r;
    endfunction

    state_t        state_q, state_d;
    logic [BW-1:0] buf_q, buf_d;
    logic [3:0]    len_q, len_d;
    logic [1:0]    err_q, err_d, code_q, code_d;
    logic          ready_q, ready_d, valid_q, valid_d, error_q, error_d;
    logic [6:0]    opcode_q, opcode_d, funct7_q, funct7_d;
    logic [2:0]    funct3_q, funct3_d, fmt_q, fmt_d;

    logic [7:0]    lc;
    logic [4:0]    letter;
    logic          is_letter, is_delim, accept;
    logic [20:0]   hit;

    always_comb begin
        lc        = char_in | 8'h20;
        is_letter = (lc >= 8'h61) && (lc <= 8'h7a);
        is_delim  = char_in inside {8'h20, 8'h09, 8'h2c, 8'h0a};
        letter    = 5'(lc - 8'h60);
        accept    = char_valid_in && ready_q;
        hit       = lookup(buf_q);
        state_d   = state_q;
        buf_d     = buf_q;
        len_d     = len_q;
        err_d     = err_q;
        valid_d   = valid_q;
        error_d   = error_q;
        code_d    = code_q;
        opcode_d  = opcode_q;
        funct7_d  = funct7_q;
        funct3_d  = funct3_q;
        fmt_d     = fmt_q;
        if (abort_in) begin
            state_d = S_IDLE;
            err_d   = E_NONE;
            {valid_d, error_d, code_d, opcode_d, funct7_d, funct3_d, fmt_d} = '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    if (is_letter) begin
                        buf_d   = {{(MAX_LEN-1){COMPRESSED__}}, letter};
                        len_d   = 4'd1;
                        err_d   = E_NONE;
                        state_d = S_COLLECT;
                    end else if (!is_delim) begin
                        err_d   = E_CHAR;
                        state_d = S_DISCARD;
                    end
                end
                S_COLLECT: if (accept) begin
                    if (is_letter && len_q < 4'(MAX_LEN)) begin
                        buf_d = {buf_q[BW-6:0], letter};
                        len_d = len_q + 4'd1;
                    end else if (is_letter) begin
                        err_d   = E_LONG;
                        state_d = S_DISCARD;
                    end else if (is_delim) begin
                        state_d = S_LOOKUP;
                    end else begin
                        err_d   = E_CHAR;
                        state_d = S_DISCARD;
                    end
                end
                S_DISCARD: if (accept && is_delim) state_d = S_LOOKUP;
                S_LOOKUP: begin
                    state_d = S_RESULT;
                    valid_d = 1'b1;
                    if (err_q != E_NONE || !hit[20]) begin
                        error_d = 1'b1;
                        code_d  = (err_q != E_NONE) ? err_q : E_UNKNOWN;
                        {opcode_d, funct7_d, funct3_d, fmt_d} = '0;
                    end else begin
                        error_d = 1'b0;
                        code_d  = E_NONE;
                        {opcode_d, funct7_d, funct3_d, fmt_d} = hit[19:0];
                    end
                end
                S_RESULT: if (result_ready_in) begin
                    state_d = S_IDLE;
                    err_d   = E_NONE;
                    {valid_d, error_d, code_d, opcode_d, funct7_d, funct3_d, fmt_d} = '0;
                end
                default: state_d = S_IDLE;
            endcase
        end
        ready_d = state_d inside {S_IDLE, S_COLLECT, S_DISCARD};
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= S_IDLE;
            buf_q    <= '0;
            len_q    <= '0;
            err_q    <= E_NONE;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            code_q   <= E_NONE;
            opcode_q <= '0;
            funct7_q <= '0;
            funct3_q <= '0;
            fmt_q    <= '0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            len_q    <= len_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
            code_q   <= code_d;
            opcode_q <= opcode_d;
            funct7_q <= funct7_d;
            funct3_q <= funct3_d;
            fmt_q    <= fmt_d;
        end
    end

    assign char_ready_out   = ready_q;
    assign result_valid_out = valid_q;
    assign error_out        = error_q;
    assign err_code_out     = code_q;
    assign opcode_out       = opcode_q;
    assign funct7_out       = funct7_q;
    assign funct3_out       = funct3_q;
    assign fmt_out          = fmt_q;
endmodule

// File: tb/tb_mnemonic_decoder.sv
// Randomised token stream against a string-level reference decoder, plus directed cases
// for reset, backpressure, abort and the error classes.
module tb_mnemonic_decoder;
    localparam int ML = 6;
`ifdef RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    logic       clk_in = 1'b0, rst_n_in = 1'b0, char_valid_in = 1'b0;
    logic       abort_in = 1'b0, result_ready_in = 1'b0;
    logic [7:0] char_in = 8'h00;
    wire        char_ready_out, result_valid_out, error_out;
    wire  [6:0] opcode_out, funct7_out;
    wire  [2:0] funct3_out, fmt_out;
    wire  [1:0] err_code_out;

    mnemonic_decoder #(.MAX_LEN(ML)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .char_valid_in(char_valid_in), .char_in(char_in),
        .char_ready_out(char_ready_out), .abort_in(abort_in), .result_valid_out(result_valid_out),
        .result_ready_in(result_ready_in), .opcode_out(opcode_out), .funct7_out(funct7_out),
        .funct3_out(funct3_out), .fmt_out(fmt_out), .error_out(error_out), .err_code_out(err_code_out)
    );

    always #5 clk_in = ~clk_in;

    int vectors = 0, miscompares = 0;
    logic [19:0] tbl [string];
    string names[$];
    logic [22:0] exp_q[$];
    string m_tok = "";
    int m_err = 0;
    bit m_in = 1'b0;

    string R_OPS[8] = '{"add", "sll", "slt", "sltu", "xor", "srl", "or", "and"};
    string I_OPS[8] = '{"addi", "slli", "slti", "sltiu", "xori", "srli", "ori", "andi"};
    string L_OPS[8] = '{"lb", "lh", "lw", "", "lbu", "lhu", "", ""};
    string S_OPS[8] = '{"sb", "sh", "sw", "", "", "", "", ""};
    string B_OPS[8] = '{"beq", "bne", "", "", "blt", "bge", "bltu", "bgeu"};
    string M_OPS[8] = '{"mul", "mulh", "mulhsu", "mulhu", "div", "divu", "rem", "remu"};
    string BAD = "$1_.@[{9";
    logic [7:0] DL[4] = '{8'h20, 8'h09, 8'h2c, 8'h0a};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [22:0] obs();
        return {error_out, err_code_out, opcode_out, funct7_out, funct3_out, fmt_out};
    endfunction

    task automatic add_op(input string n, input logic [6:0] op, input logic [6:0] f7,
                          input logic [2:0] f3, input logic [2:0] fmt, input bit in_tbl);
        if (n.len() == 0) return;
        names.push_back(n);
        if (in_tbl) tbl[n] = {op, f7, f3, fmt};
    endtask

    task automatic build();
        for (int i = 0; i < 8; i++) begin
            add_op(R_OPS[i], 7'h33, 7'h00, 3'(i), 3'd0, 1'b1);
            add_op(I_OPS[i], 7'h13, 7'h00, 3'(i), 3'd1, 1'b1);
            add_op(L_OPS[i], 7'h03, 7'h00, 3'(i), 3'd1, 1'b1);
            add_op(S_OPS[i], 7'h23, 7'h00, 3'(i), 3'd2, 1'b1);
            add_op(B_OPS[i], 7'h63, 7'h00, 3'(i), 3'd3, 1'b1);
            add_op(M_OPS[i], 7'h33, 7'h01, 3'(i), 3'd0, M_EN);
        end
        add_op("sub", 7'h33, 7'h20, 3'd0, 3'd0, 1'b1);
        add_op("sra", 7'h33, 7'h20, 3'd5, 3'd0, 1'b1);
        add_op("srai", 7'h13, 7'h20, 3'd5, 3'd1, 1'b1);
        add_op("lui", 7'h37, 7'h00, 3'd0, 3'd4, 1'b1);
        add_op("auipc", 7'h17, 7'h00, 3'd0, 3'd4, 1'b1);
        add_op("jal", 7'h6f, 7'h00, 3'd0, 3'd5, 1'b1);
        add_op("jalr", 7'h67, 7'h00, 3'd0, 3'd1, 1'b1);
    endtask

    // Reference tokenizer: works on whole strings, one result per finished token.
    task automatic model_feed(input logic [7:0] c, output bit done);
        logic [7:0] l;
        done = 1'b0;
        l = (c >= "A" && c <= "Z") ? c + 8'd32 : c;
        if (c == 8'h20 || c == 8'h09 || c == 8'h2c || c == 8'h0a) begin
            if (m_in) begin
                m_in = 1'b0;
                done = 1'b1;
                if (m_err != 0)           exp_q.push_back({1'b1, 2'(m_err), 20'd0});
                else if (tbl.exists(m_tok)) exp_q.push_back({3'b000, tbl[m_tok]});
                else                      exp_q.push_back({1'b1, 2'd3, 20'd0});
            end
        end else begin
            if (!m_in) begin
                m_in = 1'b1;
                m_tok = "";
                m_err = 0;
            end
            if (m_err == 0) begin
                if (!(l >= "a" && l <= "z")) m_err = 1;
                else if (m_tok.len() == ML)  m_err = 2;
                else                         m_tok = $sformatf("%s%c", m_tok, l);
            end
        end
    endtask

    task automatic get_result(input int hold, input string tag);
        logic [22:0] e;
        e = exp_q.pop_front();
        chk({tag, ":lookup"}, {result_valid_out, char_ready_out}, 2'b00);
        @(posedge clk_in); #1;
        chk({tag, ":valid"}, result_valid_out, 1'b1);
        chk({tag, ":result"}, obs(), e);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_in); #1;
            chk({tag, ":hold"}, {result_valid_out, char_ready_out, obs()}, {2'b10, e});
        end
        result_ready_in = 1'b1;
        @(posedge clk_in); #1;
        result_ready_in = 1'b0;
        chk({tag, ":release"}, {result_valid_out, char_ready_out}, 2'b01);
    endtask

    task automatic send_char(input logic [7:0] c, input int hold, input string tag);
        bit done;
        chk({tag, ":rdy"}, char_ready_out, 1'b1);
        char_valid_in = 1'b1;
        char_in = c;
        @(posedge clk_in); #1;
        char_valid_in = 1'b0;
        model_feed(c, done);
        if (done) get_result(hold, tag);
    endtask

    task automatic send_str(input string s, input int hold);
        for (int i = 0; i < s.len(); i++) send_char(s[i], hold, s);
    endtask

    initial begin
        string s, n;
        int kind, len;
        logic [7:0] c;
        build();
        #1;
        chk("reset_outputs", {obs(), result_valid_out, char_ready_out}, 25'd0);
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        chk("rdy_before_edge", char_ready_out, 1'b0);
        @(posedge clk_in); #1;
        chk("rdy_after_edge", char_ready_out, 1'b1);

        send_str("addi ", 0);
        send_str("  SRA,", 0);
        send_str("foobarb x ", 0);
        send_str("ad$d ", 0);
        send_str("sltiux ", 0);
        send_str("beq ", 5);
        send_str("mulhsu\n", 0);
        send_str("auipc\t", 1);

        // Asynchronous reset in the middle of a token.
        send_str("ad", 0);
        rst_n_in = 1'b0;
        #2;
        chk("reset_mid", {obs(), result_valid_out, char_ready_out}, 25'd0);
        m_in = 1'b0;
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        send_str("d ", 0);

        // Abort while a result is waiting.
        send_str("add", 0);
        char_valid_in = 1'b1;
        char_in = 8'h20;
        @(posedge clk_in); #1;
        char_valid_in = 1'b0;
        @(posedge clk_in); #1;
        chk("abort_pre", result_valid_out, 1'b1);
        abort_in = 1'b1;
        @(posedge clk_in); #1;
        abort_in = 1'b0;
        chk("abort_result", {result_valid_out, char_ready_out}, 2'b01);
        m_in = 1'b0;

        // Abort mid-token with a character offered in the same cycle.
        send_str("xo", 0);
        char_valid_in = 1'b1;
        char_in = "r";
        abort_in = 1'b1;
        @(posedge clk_in); #1;
        char_valid_in = 1'b0;
        abort_in = 1'b0;
        m_in = 1'b0;
        send_str("add ", 0);

        for (int t = 0; t < 200; t++) begin
            s = "";
            kind = int'($urandom_range(0, 7));
            repeat ($urandom_range(0, 2)) s = {s, " "};
            if (kind <= 4) begin
                n = names[$urandom_range(0, names.size() - 1)];
                for (int i = 0; i < n.len(); i++) begin
                    c = n[i];
                    if ($urandom_range(0, 1) == 1) c = c - 8'd32;
                    s = $sformatf("%s%c", s, c);
                end
            end else begin
                len = int'($urandom_range(1, 9));
                for (int i = 0; i < len; i++) begin
                    c = 8'h61 + 8'($urandom_range(0, 25));
                    if (kind == 7 && i == len / 2) c = BAD[$urandom_range(0, 7)];
                    s = $sformatf("%s%c", s, c);
                end
            end
            s = $sformatf("%s%c", s, DL[$urandom_range(0, 3)]);
            for (int i = 0; i < s.len(); i++) begin
                repeat ($urandom_range(0, 1)) begin @(posedge clk_in); #1; end
                send_char(s[i], int'($urandom_range(0, 3)), "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
